// File: rtl/uart_pkg.sv
// Shared constants for the configurable UART receiver: FSM encoding, parity modes
// and the default bit period for the board clock.
package uart_pkg;
  localparam int CLOCK_FREQUENCY        = 50_000_000;
  localparam int BAUD_RATE              = 115_200;
  localparam int DEFAULT_CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE + 1;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_CLEANUP = 3'd5
  } state_t;
endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchroniser for an asynchronous idle-high input; both flops reset to 1.
module bit_synchronizer (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);
  logic meta_q, sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;
endmodule

// File: rtl/uart_receiver.sv
// Configurable UART receiver: synchronised line, mid-bit sampling, start glitch
// rejection, optional parity and 1/2 stop bits with error flags on each frame.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = PARITY_NONE,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 incoming_bit,
  output logic                 has_data,
  output logic [DATA_BITS-1:0] data_received,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic [2:0]           debug_state
);
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF  = CW'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0] DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SLAST = BW'(STOP_BITS - 1);
  localparam logic          ODD   = (PARITY_MODE == PARITY_ODD);

  logic                 line;
  logic                 hist_q;
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q, frm_err_q;
  logic                 has_data_q, par_out_q, frm_out_q;
  logic [DATA_BITS-1:0] data_q;

  bit_synchronizer u_sync (
    .clk_i  (clock),
    .rst_ni (reset),
    .async_i(incoming_bit),
    .sync_o (line)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      hist_q     <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      has_data_q <= 1'b0;
      par_out_q  <= 1'b0;
      frm_out_q  <= 1'b0;
      data_q     <= '0;
    end else begin
      hist_q     <= line;
      has_data_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          bit_cnt_q <= '0;
          // Only a high-to-low transition starts a frame; a line already low is ignored.
          if (hist_q && !line) begin
            cnt_q   <= '0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_q != HALF) cnt_q <= cnt_q + 1'b1;
          else if (!line) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            state_q   <= ST_DATA;
          end else state_q <= ST_IDLE;
        end
        ST_DATA: begin
          if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
          else begin
            cnt_q   <= '0;
            shift_q <= {line, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DLAST) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
          else begin
            cnt_q     <= '0;
            par_err_q <= line ^ (^shift_q) ^ ODD;
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
          else begin
            cnt_q <= '0;
            if (!line) frm_err_q <= 1'b1;
            if (bit_cnt_q == SLAST) begin
              state_q    <= ST_CLEANUP;
              has_data_q <= 1'b1;
              data_q     <= shift_q;
              par_out_q  <= par_err_q;
              frm_out_q  <= frm_err_q | ~line;
            end else bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        ST_CLEANUP: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign has_data      = has_data_q;
  assign data_received = data_q;
  assign parity_error  = par_out_q;
  assign framing_error = frm_out_q;
  assign debug_state   = state_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench: three receivers (8N1, 8E1, 7O2) at 16 clocks/bit on one clock and reset.
module tb_uart_receiver;
  localparam int CPB = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic line_n = 1'b1, line_e = 1'b1, line_o = 1'b1;

  logic       hd_n, pe_n, fe_n;
  logic [7:0] d_n;
  logic [2:0] dbg_n;
  logic       hd_e, pe_e, fe_e;
  logic [7:0] d_e;
  logic [2:0] dbg_e;
  logic       hd_o, pe_o, fe_o;
  logic [6:0] d_o;
  logic [2:0] dbg_o;

  int n_cmp = 0;
  int n_err = 0;
  int pulses [3] = '{0, 0, 0};
  logic [2:0] prev_hd = '0;
  logic [6:0] first_o = '0, last_o = '0;

  always #5 clock = ~clock;

  uart_receiver #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_n (
    .clock(clock), .reset(reset), .incoming_bit(line_n), .has_data(hd_n),
    .data_received(d_n), .parity_error(pe_n), .framing_error(fe_n), .debug_state(dbg_n));
  uart_receiver #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_e (
    .clock(clock), .reset(reset), .incoming_bit(line_e), .has_data(hd_e),
    .data_received(d_e), .parity_error(pe_e), .framing_error(fe_e), .debug_state(dbg_e));
  uart_receiver #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut_o (
    .clock(clock), .reset(reset), .incoming_bit(line_o), .has_data(hd_o),
    .data_received(d_o), .parity_error(pe_o), .framing_error(fe_o), .debug_state(dbg_o));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: counts has_data per receiver and flags back-to-back pulses.
  always @(negedge clock) begin
    logic [2:0] hd;
    hd = {hd_o, hd_e, hd_n};
    for (int i = 0; i < 3; i++) begin
      if (hd[i]) begin
        pulses[i]++;
        check("has_data_single_cycle", {31'd0, prev_hd[i]}, 32'd0);
      end
    end
    if (hd_o) begin
      first_o = last_o;
      last_o  = d_o;
    end
    prev_hd = hd;
  end

  task automatic set_line(input int d, input logic v);
    case (d)
      0:       line_n = v;
      1:       line_e = v;
      default: line_o = v;
    endcase
  endtask

  task automatic send_bit(input int d, input logic v);
    set_line(d, v);
    repeat (CPB) @(negedge clock);
  endtask

  // pmode: 0 none, 1 even, 2 odd; pflip inverts the correct parity bit.
  task automatic send_frame(input int d, input logic [8:0] data, input int nbits,
                            input int pmode, input logic pflip, input logic stop_v,
                            input int nstop);
    logic p;
    p = 1'b0;
    send_bit(d, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      send_bit(d, data[i]);
      p = p ^ data[i];
    end
    if (pmode != 0) send_bit(d, ((pmode == 2) ? ~p : p) ^ pflip);
    for (int i = 0; i < nstop; i++) send_bit(d, stop_v);
    set_line(d, 1'b1);
  endtask

  initial begin
    int p0;
    logic saw_start;
    logic [7:0] v;

    // Reset state
    repeat (4) @(negedge clock);
    check("rst_has_data", {31'd0, hd_n}, 32'd0);
    check("rst_data", {24'd0, d_n}, 32'd0);
    check("rst_perr_ferr", {30'd0, pe_n, fe_n}, 32'd0);
    check("rst_state", {29'd0, dbg_n}, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // 8N1 0xCD
    p0 = pulses[0];
    send_frame(0, 9'h0CD, 8, 0, 1'b0, 1'b1, 1);
    check("8n1_pulses", pulses[0] - p0, 32'd1);
    check("8n1_data", {24'd0, d_n}, 32'hCD);
    check("8n1_errs", {30'd0, pe_n, fe_n}, 32'd0);
    check("8n1_state_idle", {29'd0, dbg_n}, 32'd0);

    // 8E1 0x5A with wrong parity, then 0x5B with correct parity
    p0 = pulses[1];
    send_frame(1, 9'h05A, 8, 1, 1'b1, 1'b1, 1);
    check("8e1_bad_pulses", pulses[1] - p0, 32'd1);
    check("8e1_bad_data", {24'd0, d_e}, 32'h5A);
    check("8e1_bad_perr", {31'd0, pe_e}, 32'd1);
    check("8e1_bad_ferr", {31'd0, fe_e}, 32'd0);
    send_frame(1, 9'h05B, 8, 1, 1'b0, 1'b1, 1);
    check("8e1_good_data", {24'd0, d_e}, 32'h5B);
    check("8e1_good_perr", {31'd0, pe_e}, 32'd0);

    // Start glitch of 4 cycles
    p0 = pulses[0];
    saw_start = 1'b0;
    line_n = 1'b0;
    repeat (4) @(negedge clock);
    line_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      if (dbg_n == 3'd1) saw_start = 1'b1;
    end
    check("glitch_saw_start", {31'd0, saw_start}, 32'd1);
    check("glitch_back_idle", {29'd0, dbg_n}, 32'd0);
    check("glitch_no_pulse", pulses[0] - p0, 32'd0);
    check("glitch_data_kept", {24'd0, d_n}, 32'hCD);

    // Break: 0x00 with low stop, line held low 20 more bit times
    p0 = pulses[0];
    send_frame(0, 9'h000, 8, 0, 1'b0, 1'b0, 1);
    line_n = 1'b0;
    repeat (20 * CPB) @(negedge clock);
    check("break_pulses", pulses[0] - p0, 32'd1);
    check("break_ferr", {31'd0, fe_n}, 32'd1);
    check("break_data", {24'd0, d_n}, 32'h00);
    line_n = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    send_frame(0, 9'h081, 8, 0, 1'b0, 1'b1, 1);
    check("after_break_pulses", pulses[0] - p0, 32'd2);
    check("after_break_data", {24'd0, d_n}, 32'h81);
    check("after_break_ferr", {31'd0, fe_n}, 32'd0);

    // Reset during data bit 3 of 0xA5
    p0 = pulses[0];
    v = 8'hA5;
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, v[i]);
    line_n = v[3];
    repeat (CPB / 2) @(negedge clock);
    reset = 1'b0;
    line_n = 1'b1;
    repeat (4) @(negedge clock);
    check("midrst_no_pulse", pulses[0] - p0, 32'd0);
    check("midrst_data", {24'd0, d_n}, 32'd0);
    check("midrst_errs", {30'd0, pe_n, fe_n}, 32'd0);
    check("midrst_state", {29'd0, dbg_n}, 32'd0);
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    check("postrst_no_pulse", pulses[0] - p0, 32'd0);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b1, 1);
    check("postrst_pulses", pulses[0] - p0, 32'd1);
    check("postrst_data", {24'd0, d_n}, 32'h3C);

    // 7O2 back-to-back 0x15, 0x6A
    p0 = pulses[2];
    send_frame(2, 9'h015, 7, 2, 1'b0, 1'b1, 2);
    send_frame(2, 9'h06A, 7, 2, 1'b0, 1'b1, 2);
    repeat (4) @(negedge clock);
    check("7o2_pulses", pulses[2] - p0, 32'd2);
    check("7o2_first", {25'd0, first_o}, 32'h15);
    check("7o2_second", {25'd0, last_o}, 32'h6A);
    check("7o2_errs", {30'd0, pe_o, fe_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
